// File: rtl/hash_msg_feeder.sv
// Purpose : packs a byte stream into 4-byte blocks, pads the tail, drives the hash core once per block and chains digests.
// Latency : last/4th byte accept -> core_start 1 cycle; core_done -> digest_valid 1 cycle; core_done -> pad-block core_start 2 cycles.
// Backpr. : in_ready is high only while collecting bytes; the source is stalled while a block is in flight in the core.
//
// Ports:
//   clk, rst_n                        clock, asynchronous active-low reset
//   in_data/in_valid/in_last/in_ready byte stream in (valid/ready, last marks final byte)
//   iv_in[0:3]                        initial chaining value, sampled on the first byte of a message
//   core_start/core_m/core_iv         block launch to the hash core (core_m[0] is the first byte)
//   core_d/core_done                  digest back from the hash core
//   digest/digest_valid               final message digest and its one-cycle update pulse
//   error                             sticky flag, set when the core fails to answer in time
module hash_msg_feeder #(
    parameter int         TIMEOUT  = 64,
    parameter logic [7:0] PAD_BYTE = 8'h80
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    input  logic       in_last,
    output logic       in_ready,
    input  logic [7:0] iv_in   [0:3],
    output logic       core_start,
    output logic [7:0] core_m  [0:3],
    output logic [7:0] core_iv [0:3],
    input  logic [7:0] core_d  [0:3],
    input  logic       core_done,
    output logic [7:0] digest  [0:3],
    output logic       digest_valid,
    output logic       error
);

    localparam int              CW     = $clog2(TIMEOUT);
    localparam logic [CW-1:0]   T_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0]   T_ERR  = CW'(TIMEOUT - 2);

    typedef enum logic [1:0] {
        S_COLLECT = 2'd0,
        S_LAUNCH  = 2'd1,
        S_WAIT    = 2'd2,
        S_PAD     = 2'd3
    } state_t;

    state_t        state;
    state_t        state_n;
    logic [1:0]    idx;
    logic [7:0]    chain [0:3];
    logic          msg_active;
    logic          final_blk;
    logic          pad_pending;
    logic [CW-1:0] cnt;
    logic          accept;

    assign accept     = in_valid && in_ready;
    assign core_start = (state == S_LAUNCH);
    // The chain register only moves on a core answer or on the first byte
    // of a new message, so it is stable for the whole time the core is busy.
    assign core_iv    = chain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_COLLECT;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            S_COLLECT: begin
                if (accept && (idx == 2'd3 || in_last)) begin
                    state_n = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                state_n = S_WAIT;
            end
            S_WAIT: begin
                // The last counted cycle only retires the abandoned message;
                // error was already raised when the counter arrived there.
                if (cnt == T_LAST) begin
                    state_n = S_COLLECT;
                end else if (core_done) begin
                    state_n = pad_pending ? S_PAD : S_COLLECT;
                end
            end
            S_PAD: begin
                state_n = S_LAUNCH;
            end
            default: begin
                state_n = S_COLLECT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready     <= 1'b0;
            idx          <= '0;
            msg_active   <= 1'b0;
            final_blk    <= 1'b0;
            pad_pending  <= 1'b0;
            cnt          <= '0;
            digest_valid <= 1'b0;
            error        <= 1'b0;
            for (int j = 0; j < 4; j++) begin
                chain[j]  <= '0;
                core_m[j] <= '0;
                digest[j] <= '0;
            end
        end else begin
            in_ready     <= (state_n == S_COLLECT);
            digest_valid <= 1'b0;
            case (state)
                S_COLLECT: begin
                    if (accept) begin
                        if (!msg_active) begin
                            chain <= iv_in;
                        end
                        msg_active <= 1'b1;
                        for (int j = 0; j < 4; j++) begin
                            if (j == int'(idx)) begin
                                core_m[j] <= in_data;
                            end else if (in_last && j == int'(idx) + 1) begin
                                core_m[j] <= PAD_BYTE;
                            end else if (in_last && j > int'(idx) + 1) begin
                                core_m[j] <= '0;
                            end
                        end
                        idx <= idx + 2'd1;
                        if (in_last) begin
                            // A message ending exactly on a block boundary
                            // needs a whole extra block of padding.
                            if (idx == 2'd3) begin
                                pad_pending <= 1'b1;
                            end else begin
                                final_blk <= 1'b1;
                            end
                        end
                    end
                end
                S_LAUNCH: begin
                    cnt <= '0;
                end
                S_WAIT: begin
                    cnt <= cnt + CW'(1);
                    if (cnt == T_LAST) begin
                        msg_active  <= 1'b0;
                        final_blk   <= 1'b0;
                        pad_pending <= 1'b0;
                        idx         <= '0;
                    end else begin
                        if (cnt == T_ERR && !core_done) begin
                            error <= 1'b1;
                        end
                        if (core_done) begin
                            chain <= core_d;
                            idx   <= '0;
                            if (final_blk) begin
                                digest       <= core_d;
                                digest_valid <= 1'b1;
                                final_blk    <= 1'b0;
                                msg_active   <= 1'b0;
                            end
                        end
                    end
                end
                S_PAD: begin
                    core_m[0]   <= PAD_BYTE;
                    core_m[1]   <= '0;
                    core_m[2]   <= '0;
                    core_m[3]   <= '0;
                    final_blk   <= 1'b1;
                    pad_pending <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/hash_msg_feeder.md
Name: hash_msg_feeder

Overview:
- Initiator for the Hash_light_top start/done interface.
- Accepts a byte stream (valid/ready with last), packs bytes into 4-byte blocks, pads the final block, and pulses start on the hash core once per block.
- Chains each block's digest into the next block's IV and presents the final digest per message.
- Sits between the message source and the hash core.

Parameters:
- TIMEOUT, 64, max cycles WAIT may last without core_done before error (≥2).
- PAD_BYTE, 8'h80, first padding byte; remaining pad bytes 8'h00.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- in_data  in  8  message byte.
- in_valid  in  1  in_data valid.
- in_last  in  1  final byte of message (qualified by in_valid).
- in_ready  out  1  feeder accepts byte this cycle.
- iv_in  in  [7:0] x4 (unpacked [0:3])  initial IV, sampled on first byte of each message.
- core_start  out  1  one-cycle start pulse to hash core.
- core_m  out  [7:0] x4  block to core; first byte of block in [0].
- core_iv  out  [7:0] x4  chaining value to core.
- core_d  in  [7:0] x4  core digest.
- core_done  in  1  core digest valid.
- digest  out  [7:0] x4  final message digest.
- digest_valid  out  1  one-cycle pulse, digest updated.
- error  out  1  sticky timeout flag.

Behaviour:
- Reset (async, rst_n=0):
  - All outputs and internal registers clear to 0 (in_ready=0, core_start=0, digest/core_m/core_iv=0, error=0).
  - State goes to COLLECT with byte index 0.
  - Reset mid-block or mid-WAIT abandons the message.
- Handshake: a byte transfers when in_valid && in_ready. in_ready=1 only in COLLECT.
- COLLECT:
  - First byte of a message: chain register <= iv_in.
  - Byte k (k=0..3) goes to core_m[k]; index increments.
  - Block full (k=3) without in_last: go to LAUNCH.
  - in_last at k<3: core_m[k+1] <= PAD_BYTE, higher bytes <= 0, mark final, go to LAUNCH.
  - in_last at k=3: set pad_pending, go to LAUNCH.
- LAUNCH (1 cycle):
  - core_start=1.
  - core_iv = chain register.
  - core_m/core_iv hold stable from LAUNCH until core_done is seen; never change while core is busy.
  - Go to WAIT; timeout counter <= 0.
- WAIT: counter increments each cycle.
  - On core_done: chain <= core_d.
    - Final block: digest <= core_d, digest_valid=1 next cycle, clear flags, index=0, go to COLLECT.
    - pad_pending: core_m <= {PAD_BYTE,0,0,0}, mark final, clear pad_pending, go to LAUNCH.
    - Otherwise: index=0, go to COLLECT.
  - Counter reaches TIMEOUT-1 without core_done: error <= 1, drop message, go to COLLECT. Error clears only on reset.
- core_done outside WAIT is ignored.
- Latency:
  - Accept of 4th/last byte -> core_start: 1 cycle.
  - core_done -> digest_valid: 1 cycle.
  - core_done -> next core_start (pad block): 2 cycles.
- Empty messages are not supported; in_last always carries a byte.
- digest holds its value until the next digest_valid.

Test Plan:
- Bench core stub: d = m XOR iv, done 5 cycles after start; iv_in = 34 55 0F 14.
- Message 11 22 33 (last on 33) -> one core_start with core_m = 11 22 33 80, core_iv = 34 55 0F 14; digest = 25 77 3C 94, one digest_valid pulse.
- Message 01 02 03 04 (last on 04) -> two core_starts:
  - Block 1: core_m = 01 02 03 04, iv = 34 55 0F 14, d = 35 57 0C 10.
  - Block 2: core_m = 80 00 00 00, iv = 35 57 0C 10.
  - digest = B5 57 0C 10.
- Stability: in_valid=1 with in_data changing every cycle during WAIT -> in_ready=0, core_m/core_iv constant from core_start through core_done, no bytes lost or duplicated.
- Timeout: TIMEOUT=16, stub never asserts done -> error=1 exactly 16 cycles after core_start, in_ready=1 next cycle; a late core_done is ignored.
- Async reset during WAIT -> all outputs 0 immediately; then message 11 22 33 still gives digest 25 77 3C 94.
- Back-to-back messages 11 22 33 then 11 22 33 -> both digests 25 77 3C 94 (chain re-seeded from iv_in).
